// File: rtl/shared_reg_arbiter.sv
// Two-requester arbiter guarding a single shared data register.
// Optional ownership timeout/preemption is compiled in with SHARED_REG_ARB_TIMEOUT_EN.
module shared_reg_arbiter #(
  parameter int unsigned     WIDTH      = 8,
  parameter logic [WIDTH-1:0] INIT_VALUE = {WIDTH{1'b1}},
  parameter int unsigned     MAX_HOLD   = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [1:0]       wr_en,
  input  logic [WIDTH-1:0] wr_data0,
  input  logic [WIDTH-1:0] wr_data1,
  output logic [1:0]       gnt,
  output logic [WIDTH-1:0] data_out,
  output logic             busy,
  output logic             preempt
);

  // state  | meaning
  // S_INIT | just out of reset, no grant possible this cycle
  // S_IDLE | no owner, arbitrate pending requests
  // S_OWN0 | requester 0 owns the register
  // S_OWN1 | requester 1 owns the register
  typedef enum logic [1:0] {S_INIT, S_IDLE, S_OWN0, S_OWN1} state_t;

  state_t state, state_nxt;
  logic   ptr;
  logic   take_over0, take_over1;

  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("shared_reg_arbiter: MAX_HOLD must be within 1..255");
  end

`ifdef SHARED_REG_ARB_TIMEOUT_EN
  // Down-counter of remaining owner cycles; terminal count marks the MAX_HOLD-th cycle.
  logic [7:0] hold_cnt;
  logic       hold_tc;

  assign hold_tc    = (hold_cnt == 8'd0);
  assign take_over0 = (state == S_OWN0) && req[0] && req[1] && hold_tc;
  assign take_over1 = (state == S_OWN1) && req[1] && req[0] && hold_tc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= 8'd0;
    end else if ((state_nxt == S_OWN0 || state_nxt == S_OWN1) && state_nxt != state) begin
      hold_cnt <= 8'(MAX_HOLD - 1);
    end else if (!hold_tc) begin
      hold_cnt <= hold_cnt - 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) preempt <= 1'b0;
    else     preempt <= take_over0 || take_over1;
  end
`else
  assign take_over0 = 1'b0;
  assign take_over1 = 1'b0;
  assign preempt    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_INIT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT: state_nxt = S_IDLE;
      S_IDLE: begin
        case (req)
          2'b01:   state_nxt = S_OWN0;
          2'b10:   state_nxt = S_OWN1;
          2'b11:   state_nxt = ptr ? S_OWN1 : S_OWN0;
          default: state_nxt = S_IDLE;
        endcase
      end
      S_OWN0: begin
        if (!req[0])         state_nxt = req[1] ? S_OWN1 : S_IDLE;
        else if (take_over0) state_nxt = S_OWN1;
      end
      S_OWN1: begin
        if (!req[1])         state_nxt = req[0] ? S_OWN0 : S_IDLE;
        else if (take_over1) state_nxt = S_OWN0;
      end
      default: state_nxt = S_INIT;
    endcase
  end

  always_comb begin
    gnt = 2'b00;
    case (state)
      S_OWN0:  gnt = 2'b01;
      S_OWN1:  gnt = 2'b10;
      default: gnt = 2'b00;
    endcase
    busy = |gnt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (state == S_OWN0 && state_nxt != S_OWN0) begin
      ptr <= 1'b1;
    end else if (state == S_OWN1 && state_nxt != S_OWN1) begin
      ptr <= 1'b0;
    end
  end

  // Writes are keyed on the current owner only, so a write on the release edge still lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out <= INIT_VALUE;
    end else if (state == S_OWN0 && wr_en[0]) begin
      data_out <= wr_data0;
    end else if (state == S_OWN1 && wr_en[1]) begin
      data_out <= wr_data1;
    end
  end

endmodule
